video_clken_gen: RTL

Parametrised multi-channel clock-enable generator for the VGA/video subsystem. It runs entirely in the `refclk` domain and produces fractional-rate one-cycle enable pulses (for example 25 MHz and 33 MHz pixel strobes from 50 MHz) with phase accumulators instead of extra PLL outputs. Each channel's rate can be reprogrammed at runtime through a valid/ready config port. A lock sequencer realigns all channels and reports `locked` in place of a PLL lock flag.

---
 rtl/video_clken_pkg.sv | 16 +
 rtl/video_clken_gen_if.sv | 15 +
 rtl/video_clken_nco.sv | 45 ++++
 rtl/video_clken_gen.sv | 87 ++++++++
 4 files changed

// File: rtl/video_clken_pkg.sv
// Shared types and constants for the video clock-enable generator.
package video_clken_pkg;

    typedef enum logic {
        SETTLE,
        LOCKED
    } state_e;

    localparam logic [31:0] INC_25M_AT_50M = 32'h80000000;
    localparam logic [31:0] INC_33M_AT_50M = 32'hA8F5C28F;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_clken_gen_if.sv
// Runtime rate-configuration port: one increment write per valid/ready handshake.
interface video_clken_gen_if
    import video_clken_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned ACC_W  = 32
);
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch;
    logic [ACC_W-1:0]              cfg_inc;

    modport master (output cfg_valid, output cfg_ch, output cfg_inc, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_inc, output cfg_ready);
endinterface

// File: rtl/video_clken_nco.sv
// One phase-accumulator channel: the carry out of acc + inc becomes a one-cycle enable.
module video_clken_nco #(
    parameter int unsigned      ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] inc_i,
    output logic             pulse_o
);
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             pulse_q, pulse_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, inc_q};
        inc_d   = load ? inc_i : inc_q;
        acc_d   = acc_q;
        pulse_d = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (run) begin
            {pulse_d, acc_d} = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q   <= INC_RST;
            acc_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            inc_q   <= inc_d;
            acc_q   <= acc_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/video_clken_gen.sv
// Multi-channel fractional clock-enable generator with a settle/lock sequencer
// that clears and realigns every channel whenever an increment is rewritten.
module video_clken_gen
    import video_clken_pkg::*;
#(
    parameter int unsigned                NUM_CH      = 3,
    parameter int unsigned                ACC_W       = 32,
    parameter int unsigned                LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0]    INC_INIT    = {INC_33M_AT_50M, INC_25M_AT_50M, INC_25M_AT_50M}
) (
    input  logic               refclk,
    input  logic               rst,
    video_clken_gen_if.slave   cfg,
    output logic [NUM_CH-1:0]  outclk_en,
    output logic               locked
);
    localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             ch_hit;
    logic             relock;
    logic             run;
    logic             clr;

    assign accept = cfg.cfg_valid && cfg.cfg_ready;
    assign ch_hit = 32'(cfg.cfg_ch) < NUM_CH;
    // Out-of-range channel writes complete the handshake but leave the lock intact.
    assign relock = accept && ch_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (relock) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign cfg.cfg_ready = (state_q == LOCKED);
    assign clr           = (state_q == SETTLE) || relock;
    assign run           = (state_q == LOCKED) && !relock;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        video_clken_nco #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
        ) u_nco (
            .clk     (refclk),
            .rst     (rst),
            .run     (run),
            .clr     (clr),
            .load    (relock && (32'(cfg.cfg_ch) == i)),
            .inc_i   (cfg.cfg_inc),
            .pulse_o (outclk_en[i])
        );
    end

endmodule
